ysyx_220053_csr_trap: RTL
=========================

# ysyx_220053_csr_trap

Parametrised machine-mode CSR and trap unit for the ysyx_220053 core; the next generation of the core's CSR file. Holds mstatus, mie, mip, mtvec (direct/vectored), mscratch, mepc, mcause, mtval, mcycle, minstret and mhartid. Sequences exception entry, interrupt entry and mret. Produces the fetch redirect target for all three. Sits beside the register file in execute and is driven by the decoder and the retire logic.

## Interface
- XLEN, 64, data width of every CSR and PC port (32 or 64).
- VECTORED, 1, 1 allows mtvec.MODE=1; 0 forces MODE to 0.
- HAS_COUNTERS, 1, 0 removes mcycle/minstret; they become unimplemented.
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- csr_valid  in  1  a CSR instruction is in execute this cycle.
- csr_wen  in  1  that instruction writes; low for csrrs/csrrc with rs1=x0.
- csr_op  in  2  00 write, 01 set, 10 clear, 11 no write.
- csr_id  in  12  CSR address.
- csr_wdata  in  XLEN  rs1 or zimm operand.
- csr_rdata  out  XLEN  old value of csr_id; combinational.
- illegal_csr  out  1  access to an unimplemented CSR, or a write to a read-only CSR.
- exc_valid, exc_cause[3:0], exc_pc[XLEN], exc_tval[XLEN]  in  synchronous exception request.
- mret  in  1  mret in execute.
- instr_retire  in  1  one instruction retires this cycle.
- next_pc  in  XLEN  PC of the instruction after the retiring one; used as mepc for interrupts.
- irq_sw, irq_timer, irq_ext  in  1  level interrupt lines.
- redirect  out  1  trap entry or mret this cycle.
- redirect_pc  out  XLEN  fetch target while redirect is high.
- trap_taken  out  1  exception or interrupt entry this cycle.

## Operation
- Address map:
  - 300 mstatus: MIE[3], MPIE[7] and MPP[12:11] are writable. MPP reads 2'b11 always. All other bits read 0.
  - 304 mie: MSIE[3], MTIE[7] and MEIE[11] are writable. All other bits are 0.
  - 344 mip: read-only.
  - 305 mtvec: BASE is [XLEN-1:2]. MODE[0] is writable only if VECTORED. Bit 1 reads 0.
  - 340 mscratch: full width.
  - 341 mepc: bits [1:0] read 0.
  - 342 mcause, 343 mtval: full width.
  - B00 mcycle, B02 minstret: full width.
  - F14 mhartid: read-only, reads 0.
- Any other csr_id is unimplemented. Addresses with csr_id[11:10]=11 are read-only.
- illegal_csr = csr_valid & (unimplemented | (csr_wen & read-only)).
- New value by csr_op:
  - 00 (write): d.
  - 01 (set): old | d.
  - 10 (clear): old & ~d.
  - Commit at the clock edge only when csr_valid & csr_wen & ~illegal_csr & ~exc_valid.
- mip: MSIP/MTIP/MEIP are registered copies of irq_sw/irq_timer/irq_ext (one flop each).
- int_pend = mstatus.MIE & |(mip & mie).
- Interrupt cause priority is MEI (11) > MSI (3) > MTI (7). mcause[XLEN-1]=1 for interrupts.
- Event priority per cycle: exc_valid > interrupt > mret.
  - An interrupt is taken only if int_pend & instr_retire & ~exc_valid.
  - mret is ignored when an exception or an interrupt is taken in the same cycle.
- Exception entry:
  - mepc<=exc_pc, mcause<={0,exc_cause}, mtval<=exc_tval, MPIE<=MIE, MIE<=0.
  - redirect_pc = {BASE,2'b00}.
- Interrupt entry:
  - mepc<=next_pc, mcause<={1,cause}, mtval<=0, MPIE<=MIE, MIE<=0.
  - redirect_pc = BASE<<2 + (MODE ? 4*cause : 0).
- mret: MIE<=MPIE, MPIE<=1, redirect_pc=mepc.
- A committed CSR write and a trap in the same cycle:
  - Trap updates win for mstatus, mepc, mcause and mtval.
  - The write commits normally to all other CSRs.
- Counters, when HAS_COUNTERS=1:
  - mcycle += 1 every cycle; minstret += instr_retire.
  - Both wrap modulo 2^XLEN.
  - A committed write to a counter wins over its increment in that cycle.

## Timing
- Reset, asynchronous: every CSR clears to 0 except mstatus.MPP (reads 11). mip flops clear to 0.
- Outputs during reset: redirect=0, trap_taken=0, csr_rdata=0 for any address except mstatus (reads MPP=11).
- csr_rdata, illegal_csr, redirect, redirect_pc and trap_taken are combinational in the same cycle as their inputs. They use pre-edge state.
- All CSR updates land at the next rising edge and are visible to reads one cycle later.
- Interrupt latency: an irq line asserted before edge n sets mip at edge n. The earliest entry is in cycle n (after edge n), provided instr_retire is high.
- Reset asserted mid-operation clears state immediately. No partial trap survives.

## Test plan
- Reset, then read mstatus and mcycle -> mstatus=0x1800 and mcycle=0. After 10 cycles, mcycle=10.
- Write 0x8000_1001 to mtvec with VECTORED=1 -> reads 0x8000_1001. With VECTORED=0 -> reads 0x8000_1000.
- exc_valid with cause 11, exc_pc=0x8000_0040, tval=0, MIE=1:
  - redirect_pc = mtvec base; trap_taken=1.
  - Next cycle: mepc=0x8000_0040, mcause=11, MIE=0, MPIE=1.
- Set mie.MTIE and MIE, set mtvec=0x100|1, pulse irq_timer, hold instr_retire with next_pc=0x200:
  - Entry occurs one cycle after irq_timer is sampled into mip.
  - redirect_pc=0x11C; mcause=0x8000_0000_0000_0007; mepc=0x200.
- Sequencing:
  - mret after the above -> redirect_pc=0x200, MIE=1, MPIE=1.
  - A same-cycle mret plus exc_valid takes the exception only.
- Write to 0xF14 -> illegal_csr=1 and no state change.
- csrrs on 0x7C0 -> illegal_csr=1, rdata=0.
- Write minstret=5 in a retiring cycle -> minstret reads 5, not 6.

Source files
------------

// File: rtl/ysyx_220053_csr_trap_if.sv
// Bundle between the decoder/retire logic and the machine-mode CSR and trap unit.
// The master side drives requests; the slave side is the CSR/trap unit.
interface ysyx_220053_csr_trap_if #(
  parameter int XLEN = 64
) ();
  logic            csr_valid;
  logic            csr_wen;
  logic [1:0]      csr_op;
  logic [11:0]     csr_id;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            illegal_csr;

  logic            exc_valid;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval;
  logic            mret;
  logic            instr_retire;
  logic [XLEN-1:0] next_pc;

  logic            irq_sw;
  logic            irq_timer;
  logic            irq_ext;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            trap_taken;

  modport master (
    output csr_valid, csr_wen, csr_op, csr_id, csr_wdata,
    output exc_valid, exc_cause, exc_pc, exc_tval, mret, instr_retire, next_pc,
    output irq_sw, irq_timer, irq_ext,
    input  csr_rdata, illegal_csr, redirect, redirect_pc, trap_taken
  );

  modport slave (
    input  csr_valid, csr_wen, csr_op, csr_id, csr_wdata,
    input  exc_valid, exc_cause, exc_pc, exc_tval, mret, instr_retire, next_pc,
    input  irq_sw, irq_timer, irq_ext,
    output csr_rdata, illegal_csr, redirect, redirect_pc, trap_taken
  );
endinterface

// File: rtl/ysyx_220053_csr_trap.sv
// Machine-mode CSR file and trap sequencer: exception entry, interrupt entry and mret,
// with the fetch redirect target for each. Reads and redirect decisions use pre-edge state.
module ysyx_220053_csr_trap #(
  parameter int XLEN         = 64,
  parameter bit VECTORED     = 1'b1,
  parameter bit HAS_COUNTERS = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  ysyx_220053_csr_trap_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [XLEN-1:0] ALIGN4_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic            mstatus_mie_r;
  logic            mstatus_mpie_r;
  logic            mie_msie_r;
  logic            mie_mtie_r;
  logic            mie_meie_r;
  logic            mip_msip_r;
  logic            mip_mtip_r;
  logic            mip_meip_r;
  logic [XLEN-1:0] mtvec_r;
  logic [XLEN-1:0] mscratch_r;
  logic [XLEN-1:0] mepc_r;
  logic [XLEN-1:0] mcause_r;
  logic [XLEN-1:0] mtval_r;
  logic [XLEN-1:0] mcycle_r;
  logic [XLEN-1:0] minstret_r;

  logic [XLEN-1:0] mstatus_val_s;
  logic [XLEN-1:0] mie_val_s;
  logic [XLEN-1:0] mip_val_s;
  logic [XLEN-1:0] rdata_s;
  logic            unimpl_s;
  logic            read_only_s;
  logic            illegal_s;
  logic [XLEN-1:0] new_val_s;
  logic            commit_s;

  logic            int_pend_s;
  logic            exc_take_s;
  logic            int_take_s;
  logic            mret_take_s;
  logic            trap_take_s;
  logic [3:0]      int_cause_s;
  logic [XLEN-1:0] trap_base_s;
  logic [XLEN-1:0] vec_off_s;
  logic [XLEN-1:0] trap_cause_s;
  logic [XLEN-1:0] trap_val_s;
  logic [XLEN-1:0] trap_epc_s;
  logic [XLEN-1:0] redirect_pc_s;

  // Architectural views of the sparse status/enable/pending registers; MPP is hardwired to M.
  always_comb begin
    mstatus_val_s        = '0;
    mstatus_val_s[3]     = mstatus_mie_r;
    mstatus_val_s[7]     = mstatus_mpie_r;
    mstatus_val_s[12:11] = 2'b11;
    mie_val_s            = '0;
    mie_val_s[3]         = mie_msie_r;
    mie_val_s[7]         = mie_mtie_r;
    mie_val_s[11]        = mie_meie_r;
    mip_val_s            = '0;
    mip_val_s[3]         = mip_msip_r;
    mip_val_s[7]         = mip_mtip_r;
    mip_val_s[11]        = mip_meip_r;
  end

  // Read mux and implemented-address decode.
  always_comb begin
    rdata_s  = '0;
    unimpl_s = 1'b0;
    case (bus.csr_id)
      ADDR_MSTATUS:  rdata_s = mstatus_val_s;
      ADDR_MIE:      rdata_s = mie_val_s;
      ADDR_MIP:      rdata_s = mip_val_s;
      ADDR_MTVEC:    rdata_s = mtvec_r;
      ADDR_MSCRATCH: rdata_s = mscratch_r;
      ADDR_MEPC:     rdata_s = mepc_r;
      ADDR_MCAUSE:   rdata_s = mcause_r;
      ADDR_MTVAL:    rdata_s = mtval_r;
      ADDR_MHARTID:  rdata_s = '0;
      ADDR_MCYCLE: begin
        if (HAS_COUNTERS) begin
          rdata_s = mcycle_r;
        end else begin
          unimpl_s = 1'b1;
        end
      end
      ADDR_MINSTRET: begin
        if (HAS_COUNTERS) begin
          rdata_s = minstret_r;
        end else begin
          unimpl_s = 1'b1;
        end
      end
      default:       unimpl_s = 1'b1;
    endcase
  end

  assign read_only_s = (bus.csr_id[11:10] == 2'b11) | (bus.csr_id == ADDR_MIP);
  assign illegal_s   = bus.csr_valid & (unimpl_s | (bus.csr_wen & read_only_s));

  // Read-modify-write value for csrrw/csrrs/csrrc.
  always_comb begin
    new_val_s = rdata_s;
    case (bus.csr_op)
      2'b00:   new_val_s = bus.csr_wdata;
      2'b01:   new_val_s = rdata_s | bus.csr_wdata;
      2'b10:   new_val_s = rdata_s & ~bus.csr_wdata;
      default: new_val_s = rdata_s;
    endcase
  end

  // op 11 must not commit, otherwise it would suppress a counter increment.
  assign commit_s = bus.csr_valid & bus.csr_wen & ~illegal_s & ~bus.exc_valid &
                    (bus.csr_op != 2'b11);

  assign int_pend_s  = mstatus_mie_r & |(mip_val_s & mie_val_s);
  assign exc_take_s  = bus.exc_valid & ~rst;
  assign int_take_s  = int_pend_s & bus.instr_retire & ~bus.exc_valid & ~rst;
  assign mret_take_s = bus.mret & ~bus.exc_valid & ~int_take_s & ~rst;
  assign trap_take_s = exc_take_s | int_take_s;
  assign trap_base_s = mtvec_r & ALIGN4_MASK;

  // Interrupt cause priority: external, then software, then timer.
  always_comb begin
    int_cause_s = 4'd7;
    if (mip_meip_r & mie_meie_r) begin
      int_cause_s = 4'd11;
    end else if (mip_msip_r & mie_msie_r) begin
      int_cause_s = 4'd3;
    end else begin
      int_cause_s = 4'd7;
    end
  end

  // Values loaded on trap entry and the fetch redirect target.
  always_comb begin
    vec_off_s     = '0;
    trap_cause_s  = '0;
    trap_val_s    = '0;
    trap_epc_s    = '0;
    redirect_pc_s = '0;
    if (mtvec_r[0]) begin
      vec_off_s[5:0] = {int_cause_s, 2'b00};
    end else begin
      vec_off_s = '0;
    end
    if (exc_take_s) begin
      trap_cause_s[3:0] = bus.exc_cause;
      trap_val_s        = bus.exc_tval;
      trap_epc_s        = bus.exc_pc & ALIGN4_MASK;
    end else begin
      trap_cause_s[XLEN-1] = 1'b1;
      trap_cause_s[3:0]    = int_cause_s;
      trap_val_s           = '0;
      trap_epc_s           = bus.next_pc & ALIGN4_MASK;
    end
    if (exc_take_s) begin
      redirect_pc_s = trap_base_s;
    end else if (int_take_s) begin
      redirect_pc_s = trap_base_s + vec_off_s;
    end else if (mret_take_s) begin
      redirect_pc_s = mepc_r;
    end else begin
      redirect_pc_s = '0;
    end
  end

  // mstatus interrupt-enable stack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
    end else if (trap_take_s) begin
      mstatus_mpie_r <= mstatus_mie_r;
      mstatus_mie_r  <= 1'b0;
    end else if (mret_take_s) begin
      mstatus_mie_r  <= mstatus_mpie_r;
      mstatus_mpie_r <= 1'b1;
    end else if (commit_s && (bus.csr_id == ADDR_MSTATUS)) begin
      mstatus_mie_r  <= new_val_s[3];
      mstatus_mpie_r <= new_val_s[7];
    end
  end

  // Trap record registers; a same-cycle trap overrides a software write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mepc_r   <= '0;
      mcause_r <= '0;
      mtval_r  <= '0;
    end else if (trap_take_s) begin
      mepc_r   <= trap_epc_s;
      mcause_r <= trap_cause_s;
      mtval_r  <= trap_val_s;
    end else begin
      if (commit_s && (bus.csr_id == ADDR_MEPC)) begin
        mepc_r <= new_val_s & ALIGN4_MASK;
      end
      if (commit_s && (bus.csr_id == ADDR_MCAUSE)) begin
        mcause_r <= new_val_s;
      end
      if (commit_s && (bus.csr_id == ADDR_MTVAL)) begin
        mtval_r <= new_val_s;
      end
    end
  end

  // Software-only registers: mie, mtvec, mscratch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_msie_r <= 1'b0;
      mie_mtie_r <= 1'b0;
      mie_meie_r <= 1'b0;
      mtvec_r    <= '0;
      mscratch_r <= '0;
    end else begin
      if (commit_s && (bus.csr_id == ADDR_MIE)) begin
        mie_msie_r <= new_val_s[3];
        mie_mtie_r <= new_val_s[7];
        mie_meie_r <= new_val_s[11];
      end
      if (commit_s && (bus.csr_id == ADDR_MTVEC)) begin
        mtvec_r <= {new_val_s[XLEN-1:2], 1'b0, (VECTORED ? new_val_s[0] : 1'b0)};
      end
      if (commit_s && (bus.csr_id == ADDR_MSCRATCH)) begin
        mscratch_r <= new_val_s;
      end
    end
  end

  // One sampling flop per interrupt line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mip_msip_r <= 1'b0;
      mip_mtip_r <= 1'b0;
      mip_meip_r <= 1'b0;
    end else begin
      mip_msip_r <= bus.irq_sw;
      mip_mtip_r <= bus.irq_timer;
      mip_meip_r <= bus.irq_ext;
    end
  end

  // Free-running counters; a software write replaces that cycle's increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle_r   <= '0;
      minstret_r <= '0;
    end else if (HAS_COUNTERS) begin
      if (commit_s && (bus.csr_id == ADDR_MCYCLE)) begin
        mcycle_r <= new_val_s;
      end else begin
        mcycle_r <= mcycle_r + XLEN'(1'b1);
      end
      if (commit_s && (bus.csr_id == ADDR_MINSTRET)) begin
        minstret_r <= new_val_s;
      end else if (bus.instr_retire) begin
        minstret_r <= minstret_r + XLEN'(1'b1);
      end
    end else begin
      mcycle_r   <= '0;
      minstret_r <= '0;
    end
  end

  assign bus.csr_rdata   = rdata_s;
  assign bus.illegal_csr = illegal_s;
  assign bus.redirect    = trap_take_s | mret_take_s;
  assign bus.redirect_pc = redirect_pc_s;
  assign bus.trap_taken  = trap_take_s;

endmodule
